yarp_fetch_unit: RTL and testbench

- PC-generation and instruction-buffering stage directly upstream of the instruction-memory interface stage; sits at the front of the yarp pipeline.
- Owns the program counter and issues one fetch request per cycle.
- Captures returned instruction words into a small FIFO and presents (pc, instr) pairs to decode over a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing in-flight and buffered fetches.

---
 rtl/yarp_pkg.sv | 17 +
 rtl/yarp_fetch_fifo.sv | 67 ++++++
 rtl/yarp_fetch_unit.sv | 95 +++++++++
 tb/tb_yarp_fetch_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/yarp_pkg.sv
// rtl/yarp_pkg.sv - shared types and constants for the yarp fetch stage
package yarp_pkg;

    localparam int FETCH_ENTRY_W = 64;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        IDLE,
        RUN
    } fetch_state_e;

endpackage

// File: rtl/yarp_fetch_fifo.sv
// rtl/yarp_fetch_fifo.sv - small synchronous FIFO of (pc, instr) entries
module yarp_fetch_fifo
    import yarp_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [FETCH_ENTRY_W-1:0] push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [FETCH_ENTRY_W-1:0] head_data,
    output logic [CNT_W-1:0]         count
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_next(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_next(rd_ptr_q);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= fetch_entry_t'(push_data);
    end

    // Head reads zero when empty so decode never sees stale storage.
    assign head_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;

    overflow_chk: assert property (@(posedge clk) disable iff (!reset_n)
        (push && !pop && !flush) |-> (count_q != CNT_W'(DEPTH)));

endmodule

// File: rtl/yarp_fetch_unit.sv
// rtl/yarp_fetch_unit.sv - PC generation, fetch issue and (pc, instr) buffering for decode
module yarp_fetch_unit
    import yarp_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        fetch_req_o,
    output logic [31:0] fetch_pc_o,
    input  logic [31:0] fetch_instr_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        dec_valid_o,
    output logic [31:0] dec_pc_o,
    output logic [31:0] dec_instr_o,
    input  logic        dec_ready_i
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    logic             inflight_q, inflight_d;
    logic             kill_q, kill_d;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   credit;
    logic             issue, push, pop;
    fetch_entry_t     head, push_entry;
    logic             unused_redirect_lsbs;

    assign dec_valid_o = (count != '0);
    assign pop         = dec_valid_o && dec_ready_i;
    // Entries held plus the one in flight, less the one leaving this cycle.
    assign credit = (CNT_W + 1)'(count) + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        kill_d        = 1'b0;
        issue         = 1'b0;
        case (state_q)
            IDLE: state_d = RUN;
            RUN:  issue = !redirect_valid_i && (credit < (CNT_W + 1)'(FIFO_DEPTH));
        endcase
        if (redirect_valid_i) begin
            pc_d   = {redirect_pc_i[31:2], 2'b00};
            kill_d = inflight_q;
        end else if (issue) begin
            pc_d          = pc_q + PC_INC;
            inflight_pc_d = pc_q;
        end
        inflight_d = issue;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            inflight_q    <= 1'b0;
            kill_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            kill_q        <= kill_d;
        end
    end

    assign push       = inflight_q && !kill_q;
    assign push_entry = '{pc: inflight_pc_q, instr: fetch_instr_i};

    yarp_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid_i),
        .head_data (head),
        .count     (count)
    );

    assign fetch_req_o          = issue;
    assign fetch_pc_o           = pc_q;
    assign dec_pc_o             = head.pc;
    assign dec_instr_o          = head.instr;
    assign unused_redirect_lsbs = &{1'b0, redirect_pc_i[1:0]};

endmodule

// File: tb/tb_yarp_fetch_unit.sv
// tb/tb_yarp_fetch_unit.sv - scoreboard bench for yarp_fetch_unit
module tb_yarp_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] XMASK  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_req_o;
    logic [31:0] fetch_pc_o;
    logic [31:0] fetch_instr_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        dec_valid_o;
    logic [31:0] dec_pc_o;
    logic [31:0] dec_instr_o;
    logic        dec_ready_i;

    always #5 clk = ~clk;

    yarp_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .fetch_req_o      (fetch_req_o),
        .fetch_pc_o       (fetch_pc_o),
        .fetch_instr_i    (fetch_instr_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .dec_valid_o      (dec_valid_o),
        .dec_pc_o         (dec_pc_o),
        .dec_instr_o      (dec_instr_o),
        .dec_ready_i      (dec_ready_i)
    );

    // One-cycle instruction memory: word = pc ^ XMASK
    logic [31:0] mem_pc = 32'h0;
    always @(posedge clk) if (fetch_req_o) mem_pc <= fetch_pc_o;
    assign fetch_instr_i = mem_pc ^ XMASK;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pops  = 0;
    int          nreq;
    logic [31:0] exp_q[$];
    logic [31:0] sb_e;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic refill(input logic [31:0] base);
        exp_q.delete();
        for (int k = 0; k < 64; k++) exp_q.push_back(base + 32'(4 * k));
    endtask

    // Handshake in a redirect cycle is checked against the old stream first.
    always @(negedge clk) begin
        if (!reset_n) begin
            refill(RST_PC);
        end else begin
            if (dec_valid_o && dec_ready_i) begin
                check_eq("sb_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    sb_e = exp_q.pop_front();
                    check_eq("sb_pc", dec_pc_o, sb_e);
                    check_eq("sb_instr", dec_instr_o, sb_e ^ XMASK);
                    n_pops++;
                end
            end
            if (redirect_valid_i) refill({redirect_pc_i[31:2], 2'b00});
        end
    end

    initial begin
        reset_n          = 1'b0;
        dec_ready_i      = 1'b1;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req", 32'(fetch_req_o), 32'd0);
        check_eq("rst_fetch_pc", fetch_pc_o, RST_PC);
        check_eq("rst_dec_valid", 32'(dec_valid_o), 32'd0);
        check_eq("rst_dec_pc", dec_pc_o, 32'h0);
        check_eq("rst_dec_instr", dec_instr_o, 32'h0);
        reset_n = 1'b1;

        // cycle 0 is IDLE; first request in cycle 1, first decode in cycle 3
        @(negedge clk); check_eq("c0_req", 32'(fetch_req_o), 32'd0);
        @(negedge clk); check_eq("c1_req", 32'(fetch_req_o), 32'd1);
        check_eq("c1_pc", fetch_pc_o, RST_PC);
        @(negedge clk); check_eq("c2_valid", 32'(dec_valid_o), 32'd0);
        @(negedge clk); check_eq("c3_valid", 32'(dec_valid_o), 32'd1);
        check_eq("c3_pc", dec_pc_o, RST_PC);
        @(negedge clk); check_eq("c4_pc", dec_pc_o, RST_PC + 32'd4);
        @(negedge clk); check_eq("c5_pc", dec_pc_o, RST_PC + 32'd8);
        repeat (3) @(negedge clk);

        // asynchronous reset mid-stream
        @(posedge clk); #2;
        check_eq("pre_rst_valid", 32'(dec_valid_o), 32'd1);
        reset_n     = 1'b0;
        dec_ready_i = 1'b0;
        #1;
        check_eq("arst_valid", 32'(dec_valid_o), 32'd0);
        check_eq("arst_req", 32'(fetch_req_o), 32'd0);
        check_eq("arst_pc", fetch_pc_o, RST_PC);

        // restart under backpressure: exactly two requests
        @(posedge clk); #1;
        reset_n = 1'b1;
        nreq = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) check_eq("bp_c0_req", 32'(fetch_req_o), 32'd0);
            if (fetch_req_o) begin
                check_eq("bp_req_pc", fetch_pc_o, RST_PC + 32'(4 * nreq));
                nreq++;
            end
        end
        check_eq("bp_req_cnt", 32'(nreq), 32'd2);
        check_eq("bp_valid", 32'(dec_valid_o), 32'd1);
        check_eq("bp_head", dec_pc_o, RST_PC);
        @(posedge clk); #1;
        dec_ready_i = 1'b1;
        repeat (6) @(negedge clk);

        // redirect with one in flight and FIFO non-empty
        @(posedge clk); #1;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h0000_2002;
        dec_ready_i      = 1'b0;
        @(negedge clk);
        check_eq("rd_fifo_busy", 32'(dec_valid_o), 32'd1);
        check_eq("rd_req_sup", 32'(fetch_req_o), 32'd0);
        @(posedge clk); #1;
        redirect_valid_i = 1'b0;
        @(negedge clk);
        check_eq("rd_flushed", 32'(dec_valid_o), 32'd0);
        check_eq("rd_req", 32'(fetch_req_o), 32'd1);
        check_eq("rd_pc", fetch_pc_o, 32'h0000_2000);
        @(negedge clk); check_eq("rd_killed", 32'(dec_valid_o), 32'd0);
        @(negedge clk); check_eq("rd_first_valid", 32'(dec_valid_o), 32'd1);
        check_eq("rd_first_pc", dec_pc_o, 32'h0000_2000);
        @(posedge clk); #1;
        dec_ready_i = 1'b1;
        repeat (5) @(negedge clk);

        // redirect with same-cycle handshake, then back-to-back redirect
        @(posedge clk); #1;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h0000_0300;
        @(negedge clk); check_eq("rr_hs_valid", 32'(dec_valid_o), 32'd1);
        @(posedge clk); #1;
        redirect_pc_i = 32'h0000_0400;
        @(negedge clk); check_eq("rr_req_sup", 32'(fetch_req_o), 32'd0);
        @(posedge clk); #1;
        redirect_valid_i = 1'b0;
        @(negedge clk); check_eq("rr_pc", fetch_pc_o, 32'h0000_0400);
        check_eq("rr_req", 32'(fetch_req_o), 32'd1);
        repeat (5) @(negedge clk);

        // PC wrap-around
        @(posedge clk); #1;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'hFFFF_FFF8;
        @(posedge clk); #1;
        redirect_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); check_eq("wr_pc0", dec_pc_o, 32'hFFFF_FFF8);
        @(negedge clk); check_eq("wr_pc1", dec_pc_o, 32'hFFFF_FFFC);
        @(negedge clk); check_eq("wr_pc2", dec_pc_o, 32'h0000_0000);
        repeat (4) @(negedge clk);

        check_eq("sb_activity", 32'(n_pops >= 20), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
